// File: rtl/ltc_sar_seq_ctrl_pkg.sv
// ltc_sar_pkg: shared FSM/mode types and table widths for the LTC233x SAR sequencer.
package ltc_sar_pkg;

   localparam int SEQ_DEPTH_DEF = 16;
   localparam int PTR_W         = $clog2(SEQ_DEPTH_DEF);
   localparam int LEN_W         = PTR_W + 1;

   typedef enum logic [2:0] {IDLE, CNV, BUSY_WAIT, SHIFT, DELAY} state_t;
   typedef enum logic {BURST = 1'b0, CONTINUOUS = 1'b1} mode_t;

endpackage

// File: rtl/ltc_sar_seq_ctrl_if.sv
// ltc_sar_seq_ctrl_if: control, table-write and pin-side signals of the SAR sequencer.
interface ltc_sar_seq_ctrl_if #(
   parameter int CTRL_W  = 8,
   parameter int N_LANES = 2
);
   import ltc_sar_pkg::*;

   logic                  mode;
   logic                  start;
   logic [15:0]           n_reads;
   logic [31:0]           sample_period;
   logic [LEN_W-1:0]      seq_len;
   logic                  seq_wr_en;
   logic [PTR_W-1:0]      seq_wr_addr;
   logic [CTRL_W-1:0]     seq_wr_data;
   logic                  busy;
   logic                  cnv;
   logic                  sclk_en;
   logic [2*N_LANES-1:0]  sdi_ddr;
   logic                  frame_done;
   logic                  read_active;
   logic                  err_busy_timeout;

   modport master (
      output mode, start, n_reads, sample_period, seq_len,
             seq_wr_en, seq_wr_addr, seq_wr_data, busy,
      input  cnv, sclk_en, sdi_ddr, frame_done, read_active, err_busy_timeout
   );

   modport slave (
      input  mode, start, n_reads, sample_period, seq_len,
             seq_wr_en, seq_wr_addr, seq_wr_data, busy,
      output cnv, sclk_en, sdi_ddr, frame_done, read_active, err_busy_timeout
   );

endinterface

// File: rtl/ltc_sar_seq_ctrl_table.sv
// ltc_seq_table: SEQ_DEPTH x CTRL_W sequence table, sync write / async read, never reset.
module ltc_seq_table
   import ltc_sar_pkg::*;
#(
   parameter int CTRL_W    = 8,
   parameter int SEQ_DEPTH = SEQ_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              i_wr_en,
   input  logic [PTR_W-1:0]  i_wr_addr,
   input  logic [CTRL_W-1:0] i_wr_data,
   input  logic [PTR_W-1:0]  i_rd_addr,
   output logic [CTRL_W-1:0] o_rd_data
);

   logic [CTRL_W-1:0] r_mem [SEQ_DEPTH];

   always_ff @(posedge clk)
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/ltc_sar_seq_ctrl.sv
// ltc_sar_seq_ctrl: CNV -> conversion wait -> DDR shift of one table word per conversion.
// Optional busy-wait timeout enabled by defining LTC_SEQ_BUSY_TIMEOUT_EN.
module ltc_sar_seq_ctrl
   import ltc_sar_pkg::*;
#(
   parameter int CTRL_W       = 8,
   parameter int N_LANES      = 2,
   parameter int SEQ_DEPTH    = SEQ_DEPTH_DEF,
   parameter int BUSY_SIGNAL  = 0,
   parameter int BUSY_CYCLES  = 28,
   parameter int SCK_CYCLES   = 12,
   parameter int BUSY_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             local_aresetn,
   ltc_sar_seq_ctrl_if.slave bus
);

`ifdef LTC_SEQ_BUSY_TIMEOUT_EN
   localparam bit TOUT_EN = 1'b1;
`else
   localparam bit TOUT_EN = 1'b0;
`endif

   state_t             r_state, w_next;
   mode_t              r_mode;
   logic [31:0]        r_cnt, r_period;
   logic [15:0]        r_rem;
   logic [LEN_W-1:0]   r_len;
   logic [PTR_W-1:0]   r_ptr;
   logic [CTRL_W-1:0]  r_word, w_rd_data;
   logic               r_seen, r_frame_done, r_read_active, r_err;
   logic               w_conv_done, w_tout, w_adv, w_wrap, w_more;

   ltc_seq_table #(.CTRL_W(CTRL_W), .SEQ_DEPTH(SEQ_DEPTH)) u_table (
      .clk       (clk),
      .i_wr_en   (bus.seq_wr_en),
      .i_wr_addr (bus.seq_wr_addr),
      .i_wr_data (bus.seq_wr_data),
      .i_rd_addr (r_ptr),
      .o_rd_data (w_rd_data)
   );

   // Fixed wait is measured from the CNV cycle, so BUSY_WAIT itself lasts BUSY_CYCLES-1
   assign w_conv_done = (BUSY_SIGNAL != 0) ? (r_seen && !bus.busy)
                                           : (r_cnt + 32'd2 >= 32'(BUSY_CYCLES));
   assign w_tout      = TOUT_EN && (BUSY_SIGNAL != 0) && (r_cnt == 32'(BUSY_TIMEOUT));
   assign w_wrap      = {1'b0, r_ptr} == r_len - 1'b1;
   assign w_more      = (r_mode == CONTINUOUS) ? bus.mode : (r_rem != 16'd0);

   always_ff @(posedge clk or negedge local_aresetn)
      if (!local_aresetn) r_state <= IDLE;
      else                r_state <= w_next;

   always_comb begin
      w_next = r_state;
      w_adv  = 1'b0;
      case (r_state)
         IDLE:      if (bus.seq_len != '0 && (bus.mode || (bus.start && bus.n_reads != 16'd0)))
                       w_next = CNV;
         CNV:       w_next = BUSY_WAIT;
         BUSY_WAIT: if (w_conv_done) w_next = SHIFT;
                    else if (w_tout) begin
                       w_next = DELAY;
                       w_adv  = 1'b1;
                    end
         SHIFT:     if (r_cnt == 32'(SCK_CYCLES - 1)) begin
                       w_next = DELAY;
                       w_adv  = 1'b1;
                    end
         DELAY:     if (r_cnt == r_period) w_next = w_more ? CNV : IDLE;
         default:   w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge local_aresetn)
      if (!local_aresetn) begin
         r_mode        <= BURST;
         r_cnt         <= '0;
         r_period      <= '0;
         r_rem         <= '0;
         r_len         <= '0;
         r_ptr         <= '0;
         r_word        <= '0;
         r_seen        <= 1'b0;
         r_frame_done  <= 1'b0;
         r_read_active <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         r_cnt         <= (w_next != r_state || r_state == IDLE) ? '0 : r_cnt + 32'd1;
         r_seen        <= (r_state == BUSY_WAIT) && (r_seen || bus.busy);
         r_frame_done  <= w_adv && w_wrap;
         r_read_active <= (r_state != IDLE) || (r_rem != 16'd0);
         if (w_tout && r_state == BUSY_WAIT) r_err <= 1'b1;
         if (r_state == IDLE) begin
            r_len    <= bus.seq_len;
            r_period <= bus.sample_period;
            r_mode   <= mode_t'(bus.mode);
            if (w_next == CNV && !bus.mode) r_rem <= bus.n_reads;
         end
         if (r_state == BUSY_WAIT && w_next == SHIFT) r_word <= w_rd_data;
         else if (r_state == SHIFT)                    r_word <= r_word << 2;
         if (w_adv) begin
            r_ptr <= w_wrap ? '0 : r_ptr + 1'b1;
            if (r_mode == BURST) r_rem <= r_rem - 16'd1;
         end else if (r_state == DELAY && w_next == IDLE) begin
            r_ptr <= '0;
         end
      end

   assign bus.cnv              = r_state == CNV;
   assign bus.sclk_en          = r_state == SHIFT;
   assign bus.sdi_ddr          = (r_state == SHIFT && r_cnt < 32'(CTRL_W / 2))
                                 ? {N_LANES{r_word[CTRL_W-1 -: 2]}} : '0;
   assign bus.frame_done       = r_frame_done;
   assign bus.read_active      = r_read_active;
   assign bus.err_busy_timeout = r_err;

endmodule

// File: tb/tb_ltc_sar_seq_ctrl.sv
// tb_ltc_sar_seq_ctrl: scoreboard bench; dut0 uses the fixed conversion wait, dut1 the busy pin.
module tb_ltc_sar_seq_ctrl;

   localparam int CW = 8;
   localparam int NL = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ltc_sar_seq_ctrl_if #(.CTRL_W(CW), .N_LANES(NL)) b0();
   ltc_sar_seq_ctrl_if #(.CTRL_W(CW), .N_LANES(NL)) b1();

   ltc_sar_seq_ctrl #(.BUSY_SIGNAL(0)) u_dut0 (.clk(clk), .local_aresetn(rst_n), .bus(b0));
   ltc_sar_seq_ctrl #(.BUSY_SIGNAL(1)) u_dut1 (.clk(clk), .local_aresetn(rst_n), .bus(b1));

   int n_run = 0;
   int n_fail = 0;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   logic [CW-1:0] exp_q[$];
   int cnv0_q[$], cnv1_q[$];
   int cyc = 0, frames = 0, fd_cnt = 0, fd_at = 0, ra_rise = 0, ra_fall = 0;
   int sh_n = 0, s1_n = 0, s1_start = 0, e1_rise = 0;
   logic [CW-1:0] sh_w, s1_w, s1_word;
   bit tail_nz, lane_bad, ra_prev, ra_seen, s1_prev, e1_prev;

   // Monitor: samples both DUTs on the falling edge and scores dut0 frames
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         sh_n = 0; tail_nz = 0; lane_bad = 0; ra_prev = 0; s1_n = 0; s1_prev = 0;
      end else begin
         if (b0.cnv) cnv0_q.push_back(cyc);
         if (b0.sclk_en) begin
            if (sh_n < CW / 2) sh_w = {sh_w[CW-3:0], b0.sdi_ddr[1:0]};
            else tail_nz |= (b0.sdi_ddr != '0);
            lane_bad |= (b0.sdi_ddr[3:2] != b0.sdi_ddr[1:0]);
            sh_n++;
         end else if (sh_n != 0) begin
            frames++;
            if (exp_q.size() == 0) check("frame_unexpected", 1, 0);
            else check("frame_word", sh_w, exp_q.pop_front());
            check("sclk_len", sh_n, 12);
            check("sdi_tail_zero", tail_nz, 0);
            check("lanes_equal", lane_bad, 0);
            sh_n = 0; tail_nz = 0; lane_bad = 0;
         end
         if (b0.frame_done) begin fd_cnt++; fd_at = frames; end
         if (b0.read_active && !ra_prev) ra_rise = cyc;
         if (!b0.read_active && ra_prev) ra_fall = cyc;
         ra_seen |= b0.read_active;
         ra_prev = b0.read_active;
         if (b1.cnv) cnv1_q.push_back(cyc);
         if (b1.sclk_en) begin
            if (!s1_prev) s1_start = cyc;
            if (s1_n < CW / 2) s1_w = {s1_w[CW-3:0], b1.sdi_ddr[1:0]};
            s1_n++;
         end else if (s1_n != 0) begin
            s1_word = s1_w;
            s1_n = 0;
         end
         s1_prev = b1.sclk_en;
         if (b1.err_busy_timeout && !e1_prev) e1_rise = cyc;
         e1_prev = b1.err_busy_timeout;
      end
   end

   task automatic step(int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic wr(int a, logic [CW-1:0] d);
      b0.seq_wr_en = 1; b0.seq_wr_addr = 4'(a); b0.seq_wr_data = d;
      b1.seq_wr_en = 1; b1.seq_wr_addr = 4'(a); b1.seq_wr_data = d;
      step(1);
      b0.seq_wr_en = 0; b1.seq_wr_en = 0;
   endtask

   task automatic burst0(int len, int n, int per);
      b0.seq_len = 5'(len); b0.n_reads = 16'(n); b0.sample_period = per; b0.start = 1;
      step(1);
      b0.start = 0;
   endtask

   task automatic burst1(int n);
      b1.seq_len = 5'd1; b1.n_reads = 16'(n); b1.sample_period = 2; b1.start = 1;
      step(1);
      b1.start = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int base, c, fall;
      b0.mode = 0; b0.start = 0; b0.n_reads = 0; b0.sample_period = 0; b0.seq_len = 0;
      b0.seq_wr_en = 0; b0.seq_wr_addr = 0; b0.seq_wr_data = 0; b0.busy = 0;
      b1.mode = 0; b1.start = 0; b1.n_reads = 0; b1.sample_period = 0; b1.seq_len = 0;
      b1.seq_wr_en = 0; b1.seq_wr_addr = 0; b1.seq_wr_data = 0; b1.busy = 0;
      step(3);
      rst_n = 1;
      step(2);
      check("rst_cnv", b0.cnv, 0);
      check("rst_sclk_en", b0.sclk_en, 0);
      check("rst_sdi", b0.sdi_ddr, 0);
      check("rst_frame_done", b0.frame_done, 0);
      check("rst_read_active", b0.read_active, 0);
      check("rst_err", b1.err_busy_timeout, 0);

      // burst of 4 over a 3-entry table
      wr(0, 8'h80); wr(1, 8'h9F); wr(2, 8'hA5);
      base = cnv0_q.size();
      c = frames;
      exp_q.push_back(8'h80); exp_q.push_back(8'h9F); exp_q.push_back(8'hA5); exp_q.push_back(8'h80);
      burst0(3, 4, 10);
      step(4 * 51 + 20);
      check("burst_cnv_count", cnv0_q.size() - base, 4);
      for (int i = 1; i < 4; i++) check("burst_cnv_gap", cnv0_q[base+i] - cnv0_q[base+i-1], 51);
      check("burst_fd_count", fd_cnt, 1);
      check("burst_fd_after_3rd", fd_at - c, 3);
      check("burst_ra_rise", ra_rise - cnv0_q[base], 1);
      check("burst_ra_fall", ra_fall - cnv0_q[base+3], 52);
      check("burst_queue_empty", exp_q.size(), 0);

      // single frame 0xB4: pairs 10,11,01,00 then zeros
      wr(0, 8'hB4);
      exp_q.push_back(8'hB4);
      burst0(1, 1, 0);
      step(60);
      check("b4_queue_empty", exp_q.size(), 0);
      check("b4_ra_idle", b0.read_active, 0);

      // continuous, mode dropped during the 5th SHIFT
      wr(0, 8'h11); wr(1, 8'h22);
      base = cnv0_q.size();
      exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h11);
      exp_q.push_back(8'h22); exp_q.push_back(8'h11);
      b0.seq_len = 2; b0.sample_period = 3; b0.mode = 1;
      for (int i = 0; i < 2000 && (cnv0_q.size() - base) < 5; i++) step(1);
      for (int i = 0; i < 100 && !b0.sclk_en; i++) step(1);
      check("cont_in_5th_shift", b0.sclk_en, 1);
      b0.mode = 0;
      step(80);
      check("cont_cnv_count", cnv0_q.size() - base, 5);
      check("cont_ra_idle", b0.read_active, 0);
      check("cont_queue_empty", exp_q.size(), 0);
      exp_q.push_back(8'h11);
      burst0(2, 1, 0);
      step(60);
      check("cont_ptr_restart", exp_q.size(), 0);

      // reset in the middle of SHIFT
      wr(0, 8'hC3); wr(1, 8'h5A);
      exp_q.push_back(8'hC3);
      burst0(2, 2, 0);
      for (int i = 0; i < 100 && !b0.sclk_en; i++) step(1);
      step(2);
      check("rst_mid_in_shift", b0.sclk_en, 1);
      rst_n = 0;
      #1;
      check("rst_mid_cnv", b0.cnv, 0);
      check("rst_mid_sclk_en", b0.sclk_en, 0);
      check("rst_mid_sdi", b0.sdi_ddr, 0);
      check("rst_mid_ra", b0.read_active, 0);
      exp_q.delete();
      step(2);
      rst_n = 1;
      step(2);
      base = cnv0_q.size();
      exp_q.push_back(8'hC3); exp_q.push_back(8'h5A);
      burst0(2, 2, 0);
      step(110);
      check("post_rst_cnv_count", cnv0_q.size() - base, 2);
      check("post_rst_queue_empty", exp_q.size(), 0);

      // no-start conditions
      base = cnv0_q.size();
      ra_seen = 0;
      burst0(0, 3, 0);
      step(10);
      burst0(2, 0, 0);
      step(10);
      check("nostart_cnv", cnv0_q.size() - base, 0);
      check("nostart_ra", ra_seen, 0);

      // busy-pin conversion wait on dut1
      wr(0, 8'h3C);
      base = cnv1_q.size();
      burst1(1);
      for (int i = 0; i < 50 && cnv1_q.size() == base; i++) step(1);
      check("busy_cnv_seen", cnv1_q.size() - base, 1);
      b1.busy = 1;
      step(20);
      b1.busy = 0;
      fall = cyc;
      step(30);
      check("busy_shift_latency", s1_start - fall, 1);
      check("busy_word", s1_word, 8'h3C);

`ifdef LTC_SEQ_BUSY_TIMEOUT_EN
      base = cnv1_q.size();
      burst1(2);
      for (int i = 0; i < 50 && cnv1_q.size() == base; i++) step(1);
      b1.busy = 1;
      for (int i = 0; i < 700 && (cnv1_q.size() - base) < 2; i++) step(1);
      check("tout_second_cnv", cnv1_q.size() - base, 2);
      check("tout_err_latency", e1_rise - cnv1_q[base], 257);
      check("tout_cnv_gap", cnv1_q[base+1] - cnv1_q[base], 260);
      step(300);
      b1.busy = 0;
      step(5);
      check("tout_err_sticky", b1.err_busy_timeout, 1);
      check("tout_ra_idle", b1.read_active, 0);
`else
      base = cnv1_q.size();
      burst1(1);
      for (int i = 0; i < 50 && cnv1_q.size() == base; i++) step(1);
      c = (cnv1_q.size() > base) ? cnv1_q[base] : cyc;
      b1.busy = 1;
      step(300);
      check("stuck_err_zero", b1.err_busy_timeout, 0);
      check("stuck_no_shift", s1_start > c, 0);
      b1.busy = 0;
      fall = cyc;
      step(20);
      check("stuck_release_shift", s1_start - fall, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
